// File: rtl/fwd_hazard_unit.sv
// Purpose : operand forwarding select and load-use hazard detection over a DEPTH-stage tag pipeline.
// Latency : stall/fwd_sel are combinational from registered tags + ID inputs; tags advance one stage per cycle.
// Backpres: ext_stall freezes the tag pipeline; stall injects a bubble into stage 1; flush empties all stages.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid/id_rd/id_regwrite/id_load   ID instruction and its destination
//   id_rs/id_rs_used           NSRC packed source addresses and their use flags
//   ext_stall, flush           external freeze, squash of in-flight instructions
//   stall                      load-use stall request
//   fwd_sel                    per-source forward select (0 = register file, k = stage k)
//   stall_cnt                  saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int AW       = 3,
    parameter int DEPTH    = 2,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 0,
    parameter int CNTW     = 16,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_load,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic                 ext_stall,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic [CNTW-1:0]      stall_cnt
);

    // Tag pipeline: index 1 is EX, index DEPTH the oldest tracked stage.
    logic [DEPTH:1]  r_v;
    logic [DEPTH:1]  r_load;
    logic [AW-1:0]   r_rd [1:DEPTH];
    logic [CNTW-1:0] r_cnt;

    logic [SELW-1:0] w_sel [NSRC];
    logic            w_stall;
    logic [AW-1:0]   w_rs;
    logic            w_src_ok;

    // Scan from the oldest stage down so the youngest matching producer
    // is the last one written and therefore wins.
    always_comb begin
        w_stall  = 1'b0;
        w_rs     = '0;
        w_src_ok = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_sel[i] = '0;
            w_rs     = id_rs[i*AW +: AW];
            w_src_ok = id_valid && id_rs_used[i] && !((ZERO_REG != 0) && (w_rs == '0));
            for (int k = DEPTH; k >= 1; k--) begin
                if (w_src_ok && r_v[k] && (r_rd[k] == w_rs))
                    w_sel[i] = SELW'(k);
            end
            // A load's data is not ready in EX; the consumer must wait a cycle.
            if ((w_sel[i] == SELW'(1)) && r_load[1])
                w_stall = 1'b1;
        end
    end

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++)
            fwd_sel[i*SELW +: SELW] = w_stall ? '0 : w_sel[i];
    end

    assign stall     = w_stall;
    assign stall_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_load <= '0;
            for (int k = 1; k <= DEPTH; k++)
                r_rd[k] <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else if (!ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_v[k]    <= r_v[k-1];
                r_rd[k]   <= r_rd[k-1];
                r_load[k] <= r_load[k-1];
            end
            // A stalled instruction enters as a bubble; it re-issues next cycle.
            r_v[1]    <= id_valid & id_regwrite & ~w_stall;
            r_rd[1]   <= id_rd;
            r_load[1] <= id_load;
        end
    end

    // Counts cycles the front end is actually held by a load-use stall;
    // frozen cycles are attributed to the external cause instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_stall && !ext_stall && (r_cnt != '1))
            r_cnt <= r_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_regwrite, id_load, ext_stall, flush;
    logic [2:0] id_rd;
    logic [5:0] id_rs;
    logic [1:0] id_rs_used;

    logic       stall_a, stall_b;
    logic [3:0] fwd_a, fwd_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A: default configuration.
    fwd_hazard_unit #(.AW(3), .DEPTH(2), .NSRC(2), .ZERO_REG(0), .CNTW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_load(id_load), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ext_stall(ext_stall), .flush(flush),
        .stall(stall_a), .fwd_sel(fwd_a), .stall_cnt(cnt_a)
    );

    // Instance B: deeper pipeline, hardwired r0, narrow counter.
    fwd_hazard_unit #(.AW(3), .DEPTH(3), .NSRC(2), .ZERO_REG(1), .CNTW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_load(id_load), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ext_stall(ext_stall), .flush(flush),
        .stall(stall_b), .fwd_sel(fwd_b), .stall_cnt(cnt_b)
    );

    // Reference model: a list of in-flight producers per instance (index 1 = youngest).
    int         depth_p [2] = '{2, 3};
    int         zero_p  [2] = '{0, 1};
    int         cmax_p  [2] = '{65535, 15};
    bit         mv  [2][8];
    bit         mld [2][8];
    int         mrd [2][8];
    int         mcnt[2];

    function automatic void model_reset();
        for (int n = 0; n < 2; n++) begin
            mcnt[n] = 0;
            for (int k = 0; k < 8; k++) begin
                mv[n][k] = 0; mld[n][k] = 0; mrd[n][k] = 0;
            end
        end
    endfunction

    function automatic void eval(input int n, output logic st, output logic [3:0] fs);
        int sel [2];
        int rs;
        st = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? int'(id_rs[2:0]) : int'(id_rs[5:3]);
            sel[i] = 0;
            if (id_valid && id_rs_used[i] && !(zero_p[n] == 1 && rs == 0)) begin
                for (int k = 1; k <= depth_p[n]; k++)
                    if (sel[i] == 0 && mv[n][k] && mrd[n][k] == rs)
                        sel[i] = k;
            end
            if (sel[i] == 1 && mld[n][1]) st = 1'b1;
        end
        fs = st ? 4'd0 : {sel[1][1:0], sel[0][1:0]};
    endfunction

    function automatic void model_step();
        logic st;
        logic [3:0] fs;
        for (int n = 0; n < 2; n++) begin
            eval(n, st, fs);
            if (flush) begin
                for (int k = 1; k < 8; k++) mv[n][k] = 0;
            end else if (!ext_stall) begin
                for (int k = depth_p[n]; k >= 2; k--) begin
                    mv[n][k] = mv[n][k-1]; mrd[n][k] = mrd[n][k-1]; mld[n][k] = mld[n][k-1];
                end
                mv[n][1]  = id_valid & id_regwrite & ~st;
                mrd[n][1] = int'(id_rd);
                mld[n][1] = id_load;
            end
            if (st && !ext_stall && mcnt[n] < cmax_p[n]) mcnt[n]++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic st;
        logic [3:0] fs;
        eval(0, st, fs);
        chk("stall_a", 32'(stall_a), 32'(st));
        chk("fwd_a",   32'(fwd_a),   32'(fs));
        chk("cnt_a",   32'(cnt_a),   32'(mcnt[0]));
        eval(1, st, fs);
        chk("stall_b", 32'(stall_b), 32'(st));
        chk("fwd_b",   32'(fwd_b),   32'(fs));
        chk("cnt_b",   32'(cnt_b),   32'(mcnt[1]));
    endtask

    task automatic drv(input logic v, input logic [2:0] rd, input logic rw, input logic ld,
                       input logic [2:0] rs0, input logic [2:0] rs1, input logic [1:0] used,
                       input logic ext, input logic fl);
        id_valid = v; id_rd = rd; id_regwrite = rw; id_load = ld;
        id_rs = {rs1, rs0}; id_rs_used = used; ext_stall = ext; flush = fl;
    endtask

    // settle: sample on the falling edge; advance: take the rising edge and step the model.
    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        settle();
        chk("rst_stall", 32'(stall_a), 0);
        chk("rst_fwd",   32'(fwd_a),   0);
        chk("rst_cnt",   32'(cnt_a),   0);
        advance();

        // Back-to-back ALU: write r3, then read it for three cycles
        drv(1, 3, 1, 0, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 3, 0, 2'b01, 0, 0); settle();
        chk("alu_fwd1", 32'(fwd_a), 32'h1);
        chk("alu_nostall", 32'(stall_a), 0);
        advance();
        settle(); chk("alu_fwd2", 32'(fwd_a), 32'h2); advance();
        settle(); chk("alu_fwd0", 32'(fwd_a), 32'h0); advance();

        // Two producers of r5, youngest wins on both sources
        do_reset();
        drv(1, 5, 1, 0, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 5, 1, 0, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 5, 5, 2'b11, 0, 0); settle();
        chk("young_fwd", 32'(fwd_a), 32'h5);
        advance();

        // Load-use: one stall cycle, then forward from stage 2
        do_reset();
        drv(1, 2, 1, 1, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 2, 0, 2'b01, 0, 0); settle();
        chk("lu_stall", 32'(stall_a), 1);
        chk("lu_fwd0",  32'(fwd_a),   0);
        chk("lu_cnt0",  32'(cnt_a),   0);
        advance();
        settle();
        chk("lu_unstall", 32'(stall_a), 0);
        chk("lu_fwd2",    32'(fwd_a),   32'h2);
        chk("lu_cnt1",    32'(cnt_a),   1);
        advance();

        // Load-use held by ext_stall for three cycles
        do_reset();
        drv(1, 2, 1, 1, 0, 0, 2'b00, 0, 0); settle(); advance();
        for (int c = 0; c < 3; c++) begin
            drv(1, 0, 0, 0, 2, 0, 2'b01, 1, 0); settle();
            chk("ext_stall_hold", 32'(stall_a), 1);
            chk("ext_cnt_hold",   32'(cnt_a),   0);
            advance();
        end
        drv(1, 0, 0, 0, 2, 0, 2'b01, 0, 0); settle();
        chk("ext_release_stall", 32'(stall_a), 1);
        advance();
        settle();
        chk("ext_done_fwd", 32'(fwd_a), 32'h2);
        chk("ext_done_cnt", 32'(cnt_a), 1);
        advance();

        // Flush while a load to r1 sits in stage 1
        do_reset();
        drv(1, 1, 1, 1, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 1, 0, 2'b01, 0, 1); settle(); advance();
        drv(1, 0, 0, 0, 1, 0, 2'b01, 0, 0); settle();
        chk("flush_stall", 32'(stall_a), 0);
        chk("flush_fwd",   32'(fwd_a),   0);
        advance();

        // r0 hardwired only in instance B
        do_reset();
        drv(1, 0, 1, 0, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 0, 0, 2'b01, 0, 0); settle();
        chk("zero_fwd_b", 32'(fwd_b), 0);
        chk("zero_fwd_a", 32'(fwd_a), 32'h1);
        advance();

        // Asynchronous reset mid-stall
        do_reset();
        drv(1, 2, 1, 1, 0, 0, 2'b00, 0, 0); settle(); advance();
        drv(1, 0, 0, 0, 2, 2, 2'b11, 0, 0); settle();
        chk("pre_rst_stall", 32'(stall_b), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stall_a", 32'(stall_a), 0);
        chk("arst_stall_b", 32'(stall_b), 0);
        chk("arst_fwd_a",   32'(fwd_a),   0);
        chk("arst_fwd_b",   32'(fwd_b),   0);
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Counter saturation: 20 load-use stalls
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drv(1, 2, 1, 1, 0, 0, 2'b00, 0, 0); settle(); advance();
            drv(1, 0, 0, 0, 2, 0, 2'b01, 0, 0); settle(); advance();
            settle(); advance();
        end
        drv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        settle();
        chk("sat_cnt_b", 32'(cnt_b), 15);
        chk("sat_cnt_a", 32'(cnt_a), 20);
        advance();

        // Randomized traffic over a small register window
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drv(($urandom_range(99) < 85), 3'($urandom_range(3)), ($urandom_range(99) < 70),
                ($urandom_range(99) < 30), 3'($urandom_range(3)), 3'($urandom_range(3)),
                2'($urandom_range(3)), ($urandom_range(99) < 10), ($urandom_range(99) < 5));
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined core, successor to the fixed 2-stage/8-register forwarding logic.
- Tracks the destination tags of in-flight instructions in an internal DEPTH-entry tag pipeline.
- For each of NSRC source operands in the ID stage, selects the youngest matching producer stage, or the register file.
- Detects load-use hazards, raises a one-cycle stall and injects a bubble. Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- AW, 3: register address width (2**AW architectural registers).
- DEPTH, 2: number of in-flight producer stages tracked (stage 1 = EX, stage 2 = MEM, ...); legal range 1..7.
- NSRC, 2: number of source operands checked per instruction.
- ZERO_REG, 0: if 1, register 0 is hardwired and never matches or forwards.
- CNTW, 16: stall counter width.
- SELW, derived as $clog2(DEPTH+1): width of each forward select field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rd  in  AW  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_load  in  1  ID instruction is a load; result is available from stage 2 onward.
- id_rs  in  NSRC*AW  source register addresses; field i is bits [i*AW +: AW].
- id_rs_used  in  NSRC  bit i set means source i is actually read.
- ext_stall  in  1  external freeze (e.g. memory wait); tag pipeline holds.
- flush  in  1  branch/exception squash of all in-flight instructions.
- stall  out  1  load-use stall request to the IF/ID/PC enables.
- fwd_sel  out  NSRC*SELW  per source: 0 = register file, k = forward from stage k.
- stall_cnt  out  CNTW  saturating count of cycles with stall=1.

Behaviour:
- Tag pipeline: entries 1..DEPTH, each holding {v, rd, load}. All v cleared on rst_n=0, asynchronously.
- Match: source i matches entry k when all of the following hold:
  - id_valid=1 and id_rs_used[i]=1;
  - entry k has v=1 and rd equal to rs field i;
  - not (ZERO_REG=1 and rs field i = 0).
- Forward select: fwd_sel field i = smallest k with a match (youngest producer wins), otherwise 0. This is purely combinational from the current state and ID inputs.
- Load-use: stall=1 when any source matches entry 1 and entry 1 has load=1, with id_valid=1. When stall=1, every fwd_sel field is driven to 0.
- Register update, in priority order:
  - flush=1: all v cleared; no shift-in. Flush overrides ext_stall and stall.
  - else ext_stall=1: all entries hold.
  - else: entry k+1 takes entry k. Entry 1 takes {id_valid & id_regwrite & ~stall, id_rd, id_load}, so a stall injects a bubble.
- Stall-to-forward sequence: in the cycle after a stall the load sits in stage 2.
  - DEPTH>=2: stall deasserts and fwd_sel = 2 for that source.
  - DEPTH=1: the load leaves tracking and the source reads the register file.
- stall_cnt: increments by 1 in every cycle with stall=1 and ext_stall=0. It holds at its maximum value (all ones) and never wraps. Reset value 0; flush does not clear it.
- Reset values: stall=0, every fwd_sel field=0, stall_cnt=0. Reset asserted mid-stall ends the stall immediately, because all entries become invalid.
- Output latency: none. stall and fwd_sel are combinational from the registered tags and the current ID inputs. The tag pipeline has one cycle of latency per stage.

Test Plan:
- Back-to-back ALU ops: cycle 0 writes r3, cycle 1 reads r3 on src0 -> fwd_sel[0]=1, stall=0. Cycle 2 reads r3 -> fwd_sel=2. Cycle 3 -> fwd_sel=0.
- Two producers of r5 in stages 1 and 2, consumer reads r5 on src0 and src1 -> both fields =1 (youngest wins).
- Load r2 followed by a consumer of r2 -> stall=1 for exactly one cycle, fwd_sel=0, stall_cnt 0->1. The next cycle gives fwd_sel=2 with stall=0, and the bubble is visible as entry 1 v=0.
- Same load-use case with ext_stall=1 held for 3 cycles -> stall stays 1, tags frozen, stall_cnt does not advance. Release ext_stall -> sequence completes as in the previous scenario.
- Flush while a load to r1 sits in entry 1 and the consumer reads r1 -> the next cycle has stall=0 and fwd_sel=0. ZERO_REG=1 with a writer and a reader of r0 -> fwd_sel stays 0.
- Reset pulse asserted asynchronously mid-stall -> stall and fwd_sel drop to 0 immediately. With CNTW=4 and 20 stall cycles, stall_cnt saturates at 15.
